scs8hd_rrarb4: RTL

Registered round-robin arbiter sharing one downstream resource (a macro built around AND-OR grant logic of the a2111o family) among up to four requesters. Requesters raise a level request, receive a one-hot registered grant, and keep ownership until they drop the request. The block sits between request sources and the shared resource's select/enable inputs, and replaces ad-hoc priority gating.

---
 rtl/scs8hd_arb_pkg.sv | 19 +
 rtl/scs8hd_arb_rrpick.sv | 29 ++
 rtl/scs8hd_rrarb4.sv | 108 ++++++++++
 3 files changed

// File: rtl/scs8hd_arb_pkg.sv
// Shared state encoding, widths and one-hot decode for the scs8hd round-robin arbiter.
// Pure declarations: no latency, no flow control.
package scs8hd_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int ID_W   = 2;
  localparam int HOLD_W = 8;

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [3:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/scs8hd_arb_rrpick.sv
// Combinational masked priority encoder: first set bit of req_i searching start_i, start_i+1, ... mod NREQ.
// Zero latency; no flow control. Bits at index >= NREQ are never visited.
module scs8hd_arb_rrpick #(
  parameter int NREQ = 4
) (
  input  logic [3:0] req_i,
  input  logic [1:0] start_i,
  output logic [3:0] win_o,
  output logic       any_o
);

  logic [1:0] idx;

  // Walk the search order backwards so the last hit is the highest-priority one.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = 2'((int'(start_i) + i) % NREQ);
      if (req_i[idx]) begin
        win_o      = '0;
        win_o[idx] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scs8hd_rrarb4.sv
// Registered round-robin arbiter for up to 4 requesters; grant appears one cycle after REQ, held until REQ drops.
// No backpressure; SC_ARB_HOLD_LIMIT_EN adds forced rotation after HOLD_MAX cycles (PREEMPT); SC_USE_PG_PIN adds power pins.
module scs8hd_rrarb4
  import scs8hd_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 15
) (
`ifdef SC_USE_PG_PIN
  input  logic            vpwr,
  input  logic            vgnd,
  input  logic            vpb,
  input  logic            vnb,
`endif
  input  logic            CLK,
  input  logic            RESETB,
  input  logic [3:0]      REQ,
  output logic [3:0]      GNT,
  output logic            GNT_VALID,
  output logic [ID_W-1:0] GNT_ID,
  output logic            PREEMPT
);

  if (NREQ < 2 || NREQ > 4 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_param
    $error("scs8hd_rrarb4: NREQ or HOLD_MAX out of range");
  end

  arb_state_e      state_q;
  logic [1:0]      ptr_q;
  logic [3:0]      gnt_q;
  logic [ID_W-1:0] gnt_id_q;
  logic            gnt_vld_q;
  logic            preempt_q;

  logic [3:0]      cand;
  logic [3:0]      win;
  logic            win_any;
  logic [ID_W-1:0] win_id;
  logic [1:0]      ptr_d;
  logic            owner_req;
  logic            hold_last;
  logic            take;
  logic            drop;

  // While BUSY the pointer already sits at owner+1, so one start index serves both cases.
  assign cand      = REQ & ~gnt_q;
  assign owner_req = |(REQ & gnt_q);

  scs8hd_arb_rrpick #(.NREQ(NREQ)) u_pick (
    .req_i   (cand),
    .start_i (ptr_q),
    .win_o   (win),
    .any_o   (win_any)
  );

  assign win_id = onehot_to_id(win);
  assign ptr_d  = (int'(win_id) == NREQ - 1) ? 2'd0 : win_id + 2'd1;

`ifdef SC_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_q;
  assign hold_last = (hold_q == HOLD_W'(HOLD_MAX - 1));
`else
  assign hold_last = 1'b0;
`endif

  assign take = win_any && (state_q == IDLE || !owner_req || hold_last);
  assign drop = (state_q == BUSY) && !owner_req && !win_any;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      preempt_q <= 1'b0;
`ifdef SC_ARB_HOLD_LIMIT_EN
      hold_q    <= '0;
`endif
    end else begin
      preempt_q <= take && owner_req;
`ifdef SC_ARB_HOLD_LIMIT_EN
      if (state_q == BUSY && !hold_last) hold_q <= hold_q + 1'b1;
`endif
      if (take) begin
        state_q   <= BUSY;
        gnt_q     <= win;
        gnt_id_q  <= win_id;
        gnt_vld_q <= 1'b1;
        ptr_q     <= ptr_d;
`ifdef SC_ARB_HOLD_LIMIT_EN
        hold_q    <= '0;
`endif
      end else if (drop) begin
        state_q   <= IDLE;
        gnt_q     <= '0;
        gnt_id_q  <= '0;
        gnt_vld_q <= 1'b0;
      end
    end
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = gnt_vld_q;
  assign GNT_ID    = gnt_id_q;
  assign PREEMPT   = preempt_q;

endmodule
